// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the frame-buffer scan-out path.
//   fb_state_t : arbiter FSM states
//   pixel_t    : 12-bit {r,g,b} pixel, 4 bits per channel
//   H_ACTIVE / V_ACTIVE / FB_PIXELS : visible raster geometry (640x480)
// -----------------------------------------------------------------------------
package vga_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } fb_state_t;

    typedef logic [11:0] pixel_t;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int FB_PIXELS = H_ACTIVE * V_ACTIVE;

endpackage

// File: rtl/pix_fifo.sv
// -----------------------------------------------------------------------------
// pix_fifo
// Small synchronous prefetch FIFO between the RAM read port and scan-out.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   flush           : empties the FIFO; overrides push and pop in that cycle
//   push, push_data : write one word (ignored when full and not popping)
//   pop             : drop the head word (ignored when empty)
//   head            : current head word (combinational read of the slot)
//   count           : number of stored words, 0..DEPTH
//   empty           : count == 0
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module pix_fifo #(
    parameter  int DATA_BITS = 12,
    parameter  int DEPTH     = 4,
    localparam int PTR_BITS  = $clog2(DEPTH),
    localparam int CNT_BITS  = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] head,
    output logic [CNT_BITS-1:0]  count,
    output logic                 empty
);

    logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0]  count_q, count_d;
    logic [DATA_BITS-1:0] slot_q [DEPTH];
    logic [DEPTH-1:0]     slot_we;
    logic                 push_ok, pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        // A full FIFO can still accept a word when the head leaves in the same cycle.
        push_ok  = push && ((count_q != CNT_BITS'(DEPTH)) || pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_BITS'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_BITS'(1);
                2'b01:   count_d = count_q - CNT_BITS'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // One write strobe per slot; the slot array itself has no reset.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot_we
            assign slot_we[gi] = push_ok && !flush && (wr_ptr_q == PTR_BITS'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_we[i]) slot_q[i] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = slot_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
// Shares one single-port frame-buffer RAM between a pixel writer and the VGA
// scan-out. Reads prefetch into a small FIFO; scan-out pops it on pixel ticks.
// Ports:
//   clk, rst_n             : clock, synchronous active-low reset
//   frame_start            : restart scan-out at address 0 (flushes prefetch)
//   pix_en, vga_active     : pixel tick and visible-area flag
//   wr_valid/wr_ready      : writer handshake, wr_addr/wr_data its payload
//   mem_en/mem_we          : RAM strobe and write enable (combinational)
//   mem_addr/mem_wdata     : RAM address and write data (combinational)
//   mem_rdata              : RAM read data, one cycle after a read strobe
//   pix_data               : registered scan-out pixel
//   underflow              : sticky, scan-out popped an empty FIFO
// ADDR_BITS is expected to equal $clog2(FB_PIXELS).
// -----------------------------------------------------------------------------
module fb_arbiter #(
    parameter int DATA_BITS  = 12,
    parameter int FB_PIXELS  = vga_pkg::FB_PIXELS,
    parameter int ADDR_BITS  = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int LOW_WATER  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 pix_en,
    input  logic                 vga_active,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_wdata,
    input  logic [DATA_BITS-1:0] mem_rdata,
    output logic [DATA_BITS-1:0] pix_data,
    output logic                 underflow
);

    import vga_pkg::*;

    localparam int CNT_BITS = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_BITS = CNT_BITS + 1;
    // One extra bit so the read pointer can sit at FB_PIXELS (end of frame).
    localparam int RA_BITS  = ADDR_BITS + 1;

    fb_state_t            state_q, state_d;
    logic [RA_BITS-1:0]   rd_addr_q, rd_addr_d;
    logic                 inflight_q, inflight_d;
    logic [DATA_BITS-1:0] pix_data_q, pix_data_d;
    logic                 underflow_q, underflow_d;

    logic [CNT_BITS-1:0]  fifo_count;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_push, fifo_pop;

    logic [OCC_BITS-1:0]  occ;
    logic                 rd_eligible, grant_rd, grant_wr;

    // Arbitration. Reads are held off in the frame_start cycle because they
    // would fetch from the old frame position and be discarded anyway.
    always_comb begin
        occ         = OCC_BITS'(fifo_count) + OCC_BITS'(inflight_q);
        rd_eligible = rst_n && !frame_start
                   && (state_q == S_FILL || state_q == S_STREAM)
                   && (occ < OCC_BITS'(FIFO_DEPTH))
                   && (rd_addr_q < RA_BITS'(FB_PIXELS));
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (!rst_n) begin
            grant_rd = 1'b0;
        end else if (rd_eligible && ((occ < OCC_BITS'(LOW_WATER)) || state_q == S_FILL)) begin
            grant_rd = 1'b1;
        end else if (wr_valid) begin
            grant_wr = 1'b1;
        end else if (rd_eligible) begin
            grant_rd = 1'b1;
        end
    end

    assign wr_ready  = grant_wr;
    assign mem_en    = grant_rd | grant_wr;
    assign mem_we    = grant_wr;
    assign mem_addr  = grant_wr ? wr_addr : rd_addr_q[ADDR_BITS-1:0];
    assign mem_wdata = grant_wr ? wr_data : '0;

    // The word returning this cycle belongs to the old frame if frame_start
    // is high, so it is dropped together with the flush.
    assign fifo_push = inflight_q && !frame_start;
    assign fifo_pop  = pix_en && vga_active && !frame_start;

    pix_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (frame_start),
        .push      (fifo_push),
        .push_data (mem_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q + RA_BITS'(grant_rd);
        inflight_d  = grant_rd;
        pix_data_d  = pix_data_q;
        underflow_d = underflow_q;
        if (frame_start) begin
            state_d     = S_FILL;
            rd_addr_d   = '0;
            pix_data_d  = '0;
            underflow_d = 1'b0;
        end else begin
            case (state_q)
                S_FILL:   if (fifo_count == CNT_BITS'(FIFO_DEPTH)) state_d = S_STREAM;
                S_STREAM: if (rd_addr_q == RA_BITS'(FB_PIXELS) && !inflight_q) state_d = S_DONE;
                default:  state_d = state_q;
            endcase
            if (pix_en) begin
                if (!vga_active) begin
                    pix_data_d = '0;
                end else if (fifo_empty) begin
                    pix_data_d  = '0;
                    underflow_d = 1'b1;
                end else begin
                    pix_data_d = fifo_head;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            pix_data_q  <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            pix_data_q  <= pix_data_d;
            underflow_q <= underflow_d;
        end
    end

    assign pix_data  = pix_data_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
// Directed bench for fb_arbiter on a 64-pixel frame. The RAM model starts with
// address n holding n[11:0] and returns read data one cycle after the strobe.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;
    import vga_pkg::*;

    localparam int DW   = 12;
    localparam int NPIX = 64;
    localparam int AW   = 6;

    logic          clk = 1'b0;
    logic          rst_n, frame_start, pix_en, vga_active;
    logic          wr_valid, wr_ready, mem_en, mem_we, underflow;
    logic [AW-1:0] wr_addr, mem_addr;
    logic [DW-1:0] wr_data, mem_wdata, mem_rdata, pix_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fb_arbiter #(
        .DATA_BITS  (DW),
        .FB_PIXELS  (NPIX),
        .ADDR_BITS  (AW),
        .FIFO_DEPTH (4),
        .LOW_WATER  (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .pix_en      (pix_en),
        .vga_active  (vga_active),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .pix_data    (pix_data),
        .underflow   (underflow)
    );

    // RAM model, preset on the first clock edge.
    logic [DW-1:0] ram [NPIX];
    logic          ram_ready = 1'b0;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < NPIX; i++) ram[i] <= DW'(i);
            ram_ready <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Frame content after the pre-frame write of 12'hFFF to address 5.
    function automatic logic [DW-1:0] exp_pix(int n);
        return (n == 5) ? 12'hFFF : DW'(n);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 12'h007;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b0 || wr_ready !== 1'b0)
                $display("FAIL reset_strobe: mem_en=%b wr_ready=%b want 0/0", mem_en, wr_ready);
            step();
        end
        @(negedge clk);
        checks++;
        if (dut.state_q !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dut.state_q, S_IDLE); end
        checks++;
        if (dut.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", dut.fifo_count); end
        checks++;
        if (pix_data !== 12'h000 || underflow !== 1'b0) begin
            failures++; $display("FAIL reset_outputs: pix_data=%h underflow=%b want 000/0", pix_data, underflow);
        end
        step();
        rst_n = 1'b1; wr_valid = 1'b0;
    endtask

    task automatic test_idle_write();
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL idle_no_read: mem_en=%b want 0", mem_en); end
        step();
        wr_valid = 1'b1; wr_addr = 6'd5; wr_data = 12'hFFF;
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 6'd5 || mem_wdata !== 12'hFFF) begin
            failures++;
            $display("FAIL idle_write: ready=%b we=%b addr=%0d wdata=%h want 1/1/5/fff", wr_ready, mem_we, mem_addr, mem_wdata);
        end
        $display("write addr=5 data=fff");
        step();
        wr_valid = 1'b0;
    endtask

    task automatic test_fill();
        frame_start = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0) begin failures++; $display("FAIL fill_fs_cycle: mem_en=%b want 0", mem_en); end
        step();
        frame_start = 1'b0; wr_valid = 1'b1; wr_addr = 6'd40; wr_data = 12'd40;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(i) || wr_ready !== 1'b0) begin
                failures++;
                $display("FAIL fill_read[%0d]: en=%b we=%b addr=%0d ready=%b want 1/0/%0d/0", i, mem_en, mem_we, mem_addr, wr_ready, i);
            end
            $display("read addr=%0d", mem_addr);
            step();
        end
        @(negedge clk);
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL fill_write_after: wr_ready=%b want 1", wr_ready); end
        step();
        repeat (3) step();
        @(negedge clk);
        checks++;
        if (dut.state_q !== S_STREAM || dut.fifo_count !== 3'd4) begin
            failures++;
            $display("FAIL fill_state: state=%0d count=%0d want %0d/4", dut.state_q, dut.fifo_count, S_STREAM);
        end
        step();
    endtask

    task automatic test_stream();
        int wr_grants;
        wr_grants = 0;
        vga_active = 1'b1;
        for (int p = 0; p < NPIX; p++) begin
            if (p == 20) begin
                // Blanked pixel tick: output must be 0 and no word consumed.
                vga_active = 1'b0; pix_en = 1'b1;
                step();
                pix_en = 1'b0;
                @(negedge clk);
                checks++;
                if (pix_data !== 12'h000) begin failures++; $display("FAIL stream_blank: got %h want 000", pix_data); end
                step();
                vga_active = 1'b1;
            end
            pix_en = 1'b1;
            @(negedge clk);
            if (p < 20) wr_grants += int'(wr_ready);
            step();
            pix_en = 1'b0;
            @(negedge clk);
            if (p < 20) wr_grants += int'(wr_ready);
            checks++;
            if (pix_data !== exp_pix(p) || underflow !== 1'b0) begin
                failures++;
                $display("FAIL stream_pix[%0d]: got %h uf=%b want %h uf=0", p, pix_data, underflow, exp_pix(p));
            end
            $display("pixel %0d data=%h", p, pix_data);
            step();
        end
        checks++;
        if (wr_grants < 15 || wr_grants > 25) begin
            failures++; $display("FAIL stream_wr_share: got %0d grants in 40 cycles want 15..25", wr_grants);
        end
        checks++;
        if (dut.state_q !== S_DONE) begin failures++; $display("FAIL stream_done: state=%0d want %0d", dut.state_q, S_DONE); end
    endtask

    task automatic test_underflow();
        for (int p = 0; p < 3; p++) begin
            pix_en = 1'b1;
            @(negedge clk);
            checks++;
            if (mem_en === 1'b1 && mem_we === 1'b0) begin failures++; $display("FAIL done_no_read: read strobe at addr %0d", mem_addr); end
            step();
            pix_en = 1'b0;
            @(negedge clk);
            checks++;
            if (pix_data !== 12'h000 || underflow !== 1'b1) begin
                failures++; $display("FAIL underflow[%0d]: pix=%h uf=%b want 000/1", p, pix_data, underflow);
            end
            step();
        end
        frame_start = 1'b1; pix_en = 1'b1;
        step();
        frame_start = 1'b0; pix_en = 1'b0;
        @(negedge clk);
        checks++;
        if (underflow !== 1'b0 || pix_data !== 12'h000 || dut.state_q !== S_FILL) begin
            failures++; $display("FAIL underflow_clear: uf=%b pix=%h state=%0d want 0/000/%0d", underflow, pix_data, dut.state_q, S_FILL);
        end
        step();
    endtask

    task automatic test_restart_inflight();
        wr_valid = 1'b0; pix_en = 1'b0; vga_active = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 6'd2) begin
            failures++; $display("FAIL restart_pre_read: en=%b we=%b addr=%0d want 1/0/2", mem_en, mem_we, mem_addr);
        end
        step();
        // Word from addr 2 arrives now; frame_start collides with pop and push.
        frame_start = 1'b1; pix_en = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.inflight_q !== 1'b1) begin failures++; $display("FAIL restart_inflight: got %b want 1", dut.inflight_q); end
        step();
        frame_start = 1'b0; pix_en = 1'b0;
        @(negedge clk);
        checks++;
        if (dut.fifo_count !== 3'd0 || pix_data !== 12'h000 || mem_addr !== 6'd0 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL restart_flush: count=%0d pix=%h addr=%0d en=%b want 0/000/0/1", dut.fifo_count, pix_data, mem_addr, mem_en);
        end
        step();
        repeat (6) step();
        for (int p = 0; p < 4; p++) begin
            pix_en = 1'b1;
            step();
            pix_en = 1'b0;
            @(negedge clk);
            checks++;
            if (pix_data !== exp_pix(p)) begin failures++; $display("FAIL restart_pix[%0d]: got %h want %h", p, pix_data, exp_pix(p)); end
            $display("pixel %0d data=%h", p, pix_data);
            step();
        end
    endtask

    task automatic test_reset_midframe();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0; pix_en = 1'b1;
        step();
        pix_en = 1'b0;
        repeat (8) step();
        for (int p = 0; p < 2; p++) begin
            pix_en = 1'b1;
            step();
            pix_en = 1'b0;
            step();
        end
        @(negedge clk);
        checks++;
        if (pix_data !== 12'h001 || underflow !== 1'b1) begin
            failures++; $display("FAIL midframe_pre: pix=%h uf=%b want 001/1", pix_data, underflow);
        end
        step();
        rst_n = 1'b0; wr_valid = 1'b1; pix_en = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_en !== 1'b0 || wr_ready !== 1'b0) begin
            failures++; $display("FAIL midframe_strobe: mem_en=%b wr_ready=%b want 0/0", mem_en, wr_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (dut.state_q !== S_IDLE || dut.fifo_count !== 3'd0 || dut.rd_addr_q !== 7'd0 || dut.inflight_q !== 1'b0) begin
            failures++;
            $display("FAIL midframe_regs: state=%0d count=%0d rd_addr=%0d inflight=%b want %0d/0/0/0",
                     dut.state_q, dut.fifo_count, dut.rd_addr_q, dut.inflight_q, S_IDLE);
        end
        checks++;
        if (pix_data !== 12'h000 || underflow !== 1'b0) begin
            failures++; $display("FAIL midframe_outputs: pix=%h uf=%b want 000/0", pix_data, underflow);
        end
        step();
        rst_n = 1'b1; wr_valid = 1'b0; pix_en = 1'b0;
        step();
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pix_en = 1'b0; vga_active = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        step();
        test_reset();
        test_idle_write();
        test_fill();
        test_stream();
        test_underflow();
        test_restart_inflight();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
